uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_parity_calc.sv | 15 +
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both transmitter and receiver:
// FSM state encoding, default word width and bit-period helper.
package uart_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // A programmed period of 0 behaves like a period of 1 cycle.
    function automatic logic [4:0] bit_period_m1(input logic [4:0] ps);
        return (ps == 5'd0) ? 5'd0 : (ps - 5'd1);
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit generator for the UART transmitter: even parity when PAR_TYP=0,
// odd parity when PAR_TYP=1.
module parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             PAR_TYP,
    output logic             par_bit
);

    assign par_bit = (^data) ^ PAR_TYP;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic [4:0]       prescale,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    uart_state_e      r_state;
    uart_state_e      w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic [4:0]       r_ps_cnt;
    logic [4:0]       w_ps_cnt_next;
    logic [4:0]       r_period_m1;
    logic [WIDTH-1:0] r_data;
    logic             r_tx;
    logic             r_busy;
    logic             w_tx_next;
    logic             w_accept;
    logic             w_bit_done;

    assign w_accept   = (r_state == IDLE) && DATA_VALID;
    assign w_bit_done = (r_ps_cnt == r_period_m1);

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_typ;
    logic w_par_bit;

    // Parity configuration captured with the word it applies to.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end else begin
            r_par_en  <= r_par_en;
            r_par_typ <= r_par_typ;
        end
    end

    parity_calc #(.WIDTH(WIDTH)) u_parity_calc (
        .data    (r_data),
        .PAR_TYP (r_par_typ),
        .par_bit (w_par_bit)
    );
`else
    logic w_unused_par;
    assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Next-state, counters and the line level that the next state will drive.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_ps_cnt_next  = w_bit_done ? 5'd0 : (r_ps_cnt + 5'd1);
        w_tx_next      = 1'b1;

        case (r_state)
            IDLE: begin
                w_ps_cnt_next = 5'd0;
                if (DATA_VALID) begin
                    w_state_next = START;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = START;
                end
            end
            DATA: begin
                if (w_bit_done && (r_bit_cnt == LAST_BIT)) begin
                    w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_state_next = r_par_en ? PARITY : STOP;
`else
                    w_state_next = STOP;
`endif
                end else if (w_bit_done) begin
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                end else begin
                    w_state_next = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                end else begin
                    w_state_next = PARITY;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = STOP;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_bit_cnt_next = '0;
                w_ps_cnt_next  = 5'd0;
            end
        endcase

        // TX_OUT is registered, so it is derived from where the FSM is going.
        case (w_state_next)
            IDLE:    w_tx_next = 1'b1;
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_data[w_bit_cnt_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = w_par_bit;
`endif
            STOP:    w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    // State, counters, latched request and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_ps_cnt    <= 5'd0;
            r_period_m1 <= 5'd0;
            r_data      <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_ps_cnt  <= w_ps_cnt_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != IDLE);
            if (w_accept) begin
                r_data      <= P_DATA;
                r_period_m1 <= bit_period_m1(prescale);
            end else begin
                r_data      <= r_data;
                r_period_m1 <= r_period_m1;
            end
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: frame shapes, timing, back-to-back requests,
// input changes mid-frame, prescale 0 and asynchronous reset mid-frame.
module tb_uart_tx;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b1;
    logic [7:0] P_DATA     = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN     = 1'b0;
    logic       PAR_TYP    = 1'b0;
    logic [4:0] prescale   = 5'd0;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a one-shot request at a falling edge; returns in the first START cycle.
    task automatic request(input logic [7:0] d, input logic pen, input logic ptyp, input logic [4:0] ps);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        prescale   = ps;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    // Checks every cycle of one frame against exp_bits (index 0 = start bit),
    // samples mid-bit like a receiver, and ends on the first idle cycle.
    task automatic run_frame(input string tag, input logic [10:0] exp_bits, input int nbits,
                             input int n, input logic [7:0] exp_rx, input logic typ,
                             input logic chg, input logic [7:0] chg_val);
        int busy_cnt;
        logic [10:0] rx;
        logic rx_valid;
        busy_cnt = 0;
        rx = 11'd0;
        for (int k = 0; k < nbits * n; k++) begin
            if (k > 0) @(negedge CLK);
            if (chg && (k == 3 * n + 1)) begin
                P_DATA   = chg_val;
                prescale = 5'd2;
            end
            check($sformatf("%s tx[%0d]", tag, k), {31'd0, TX_OUT}, {31'd0, exp_bits[k / n]});
            if (busy === 1'b1) busy_cnt++;
            if ((k % n) == (n / 2)) rx[k / n] = TX_OUT;
        end
        @(negedge CLK);
        check({tag, " busy_len"}, busy_cnt, nbits * n);
        check({tag, " idle_tx"}, {31'd0, TX_OUT}, 32'd1);
        check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, " rx_data"}, {24'd0, rx[8:1]}, {24'd0, exp_rx});
        rx_valid = rx[nbits - 1] && ((nbits != 11) || (rx[9] == ((^rx[8:1]) ^ typ)));
        check({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        #1 RST = 1'b0;
        #1;
        check("rst tx", {31'd0, TX_OUT}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("post_rst tx", {31'd0, TX_OUT}, 32'd1);
        check("post_rst busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        check("post_rst2 busy", {31'd0, busy}, 32'd0);

        // 0x55, no parity, 8 cycles per bit
        request(8'h55, 1'b0, 1'b0, 5'd8);
        run_frame("f55", 11'b0_1010101010, 10, 8, 8'h55, 1'b0, 1'b0, 8'h00);

        // 0x0F, no parity
        request(8'h0F, 1'b0, 1'b0, 5'd8);
        run_frame("f0F", 11'b0_1000011110, 10, 8, 8'h0F, 1'b0, 1'b0, 8'h00);

`ifdef UART_TX_PARITY_EN
        request(8'h55, 1'b1, 1'b0, 5'd8);
        run_frame("f55_even", 11'b10010101010, 11, 8, 8'h55, 1'b0, 1'b0, 8'h00);
        request(8'h55, 1'b1, 1'b1, 5'd8);
        run_frame("f55_odd", 11'b11010101010, 11, 8, 8'h55, 1'b1, 1'b0, 8'h00);
`else
        // Parity inputs have no effect in this build
        request(8'h55, 1'b1, 1'b0, 5'd8);
        run_frame("f55_pen_even", 11'b0_1010101010, 10, 8, 8'h55, 1'b0, 1'b0, 8'h00);
        request(8'h55, 1'b1, 1'b1, 5'd8);
        run_frame("f55_pen_odd", 11'b0_1010101010, 10, 8, 8'h55, 1'b1, 1'b0, 8'h00);
`endif

        // Back-to-back with DATA_VALID held; P_DATA and prescale change mid-frame
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 5'd3;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        run_frame("b2b_3C", 11'b0_1001111000, 10, 3, 8'h3C, 1'b0, 1'b1, 8'hC5);
        @(negedge CLK);
        run_frame("b2b_C5", 11'b0_1110001010, 10, 2, 8'hC5, 1'b0, 1'b0, 8'h00);
        DATA_VALID = 1'b0;
        @(negedge CLK);
        check("b2b_end busy", {31'd0, busy}, 32'd0);
        check("b2b_end tx", {31'd0, TX_OUT}, 32'd1);

        // Asynchronous reset during the data bits
        request(8'hF0, 1'b0, 1'b0, 5'd4);
        repeat (6) @(negedge CLK);
        check("mid pre_rst tx", {31'd0, TX_OUT}, 32'd0);
        check("mid pre_rst busy", {31'd0, busy}, 32'd1);
        RST = 1'b0;
        #1;
        check("mid rst tx", {31'd0, TX_OUT}, 32'd1);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("mid rel tx", {31'd0, TX_OUT}, 32'd1);
        check("mid rel busy", {31'd0, busy}, 32'd0);

        // Prescale 0 behaves as one cycle per bit
        request(8'hA3, 1'b0, 1'b0, 5'd0);
        run_frame("fA3_ps0", 11'b0_1101000110, 10, 1, 8'hA3, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
